// File: rtl/mpc_dot_pkg.sv
// Shared constants and types for the MPC dot-product accumulator.
package mpc_dot_pkg;

    localparam int PROD_WIDTH = 28;
    localparam int MAX_LEN    = 64;
    localparam int ACC_WIDTH  = 34;
    localparam int SHIFT      = 7;
    localparam int OUT_WIDTH  = 21;

    // ACC: collecting beats of a burst; HOLD: a finished result sits in the output register.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/mpc_dot_round_sat.sv
// Combinational round-half-up, arithmetic right shift and signed saturation.
module mpc_dot_round_sat #(
    parameter int ACC_WIDTH = 34,
    parameter int SHIFT     = 7,
    parameter int OUT_WIDTH = 21
) (
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        sat_out
);

    // One guard bit so the rounding add can never wrap.
    localparam int RW = ACC_WIDTH + 1;

    localparam logic signed [RW-1:0] HALF    = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [RW-1:0] MAX_POS = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_NEG = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [RW-1:0] rounded;
    logic signed [RW-1:0] shifted;

    // Round, shift, then clip into the output range.
    always_comb begin
        rounded  = {acc_in[ACC_WIDTH-1], acc_in} + HALF;
        shifted  = rounded >>> SHIFT;
        data_out = shifted[OUT_WIDTH-1:0];
        sat_out  = 1'b0;
        if (shifted > MAX_POS) begin
            data_out = MAX_POS[OUT_WIDTH-1:0];
            sat_out  = 1'b1;
        end else if (shifted < MIN_NEG) begin
            data_out = MIN_NEG[OUT_WIDTH-1:0];
            sat_out  = 1'b1;
        end
    end

endmodule

// File: rtl/mpc_dot_acc.sv
// Streaming dot-product accumulator: sums a framed burst of products, rescales,
// saturates and presents the result through a single-entry valid/ready register.
module mpc_dot_acc #(
    parameter int PROD_WIDTH = mpc_dot_pkg::PROD_WIDTH,
    parameter int MAX_LEN    = mpc_dot_pkg::MAX_LEN,
    parameter int ACC_WIDTH  = mpc_dot_pkg::ACC_WIDTH,
    parameter int SHIFT      = mpc_dot_pkg::SHIFT,
    parameter int OUT_WIDTH  = mpc_dot_pkg::OUT_WIDTH,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [PROD_WIDTH-1:0] in_prod,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic                  out_err,
    output logic [LEN_WIDTH-1:0]  out_len
);

    import mpc_dot_pkg::*;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  first_q, first_d;
    logic [OUT_WIDTH-1:0]  data_q, data_d;
    logic                  sat_q, sat_d;
    logic                  err_q, err_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;

    logic                  accept;
    logic                  pop;
    logic                  terminate;
    logic                  at_max;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic [LEN_WIDTH-1:0]  cnt_inc;
    logic [OUT_WIDTH-1:0]  rs_data;
    logic                  rs_sat;

    // Handshake qualifiers; pop is gated by ce so a transfer only completes when enabled.
    assign accept = in_valid & in_ready;
    assign pop    = ce & out_valid & out_ready;

    // Next partial sum, beat count and burst-termination decode for the current beat.
    always_comb begin
        acc_sum   = (first_q ? '0 : acc_q)
                  + {{(ACC_WIDTH-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
        cnt_inc   = first_q ? LEN_WIDTH'(1) : cnt_q + LEN_WIDTH'(1);
        at_max    = (cnt_inc == LEN_WIDTH'(MAX_LEN));
        terminate = in_last | at_max;
    end

    mpc_dot_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round_sat (
        .acc_in   (acc_sum),
        .data_out (rs_data),
        .sat_out  (rs_sat)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a new result in the same cycle as a pop keeps us in HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:  if (accept && terminate) state_d = HOLD;
            HOLD: if (pop && !(accept && terminate)) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // FSM outputs: result valid while holding, input open when the slot is free or draining.
    always_comb begin
        out_valid = (state_q == HOLD);
        in_ready  = ce & (~out_valid | out_ready);
    end

    // Datapath next values: accumulate on every accepted beat, capture on termination.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        data_d  = data_q;
        sat_d   = sat_q;
        err_d   = err_q;
        len_d   = len_q;
        if (accept) begin
            acc_d   = acc_sum;
            cnt_d   = cnt_inc;
            first_d = terminate;
            if (terminate) begin
                data_d = rs_data;
                sat_d  = rs_sat;
                // Only a forced stop at the length limit is an error.
                err_d  = ~in_last;
                len_d  = cnt_inc;
            end
        end
    end

    // Datapath registers; reset discards any partial sum and pending result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            data_q  <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            len_q   <= len_d;
        end
    end

    assign out_data = data_q;
    assign out_sat  = sat_q;
    assign out_err  = err_q;
    assign out_len  = len_q;

endmodule

// File: tb/tb_mpc_dot_acc.sv
// Bench for mpc_dot_acc: integer-arithmetic reference model checked every cycle,
// plus directed bursts with hand-computed results.
module tb_mpc_dot_acc;

    localparam int  PW     = 28;
    localparam int  OW     = 21;
    localparam int  LW     = 7;
    localparam int  LEN    = 64;
    localparam int  SH     = 7;
    localparam longint OMAX = 1048575;
    localparam longint OMIN = -1048576;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ce;
    logic          in_valid;
    logic [PW-1:0] in_prod;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_sat;
    logic          out_err;
    logic [LW-1:0] out_len;

    always #5 clk = ~clk;

    mpc_dot_acc dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_err   (out_err),
        .out_len   (out_len)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        longint data;
        bit     sat;
        bit     err;
        int     len;
    } res_t;

    res_t cap_q[$];

    // Reference model state: plain integer sum and beat count for the open burst,
    // plus the result the output register should be showing.
    longint m_sum;
    int     m_cnt;
    bit     m_first;
    bit     m_valid;
    longint m_data;
    bit     m_sat;
    bit     m_err;
    int     m_len;
    bit     m_accepted;

    task automatic model_reset();
        m_sum = 0; m_cnt = 0; m_first = 1'b1; m_valid = 1'b0;
        m_data = 0; m_sat = 1'b0; m_err = 1'b0; m_len = 0; m_accepted = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                bit     rdy, acc, pop, done;
                longint s, r;
                int     n;
                rdy = ce && (!m_valid || out_ready);
                acc = in_valid && rdy;
                pop = ce && m_valid && out_ready;
                m_accepted = acc;
                if (pop) m_valid = 1'b0;
                if (acc) begin
                    s = (m_first ? 64'sd0 : m_sum) + longint'($signed(in_prod));
                    n = m_first ? 1 : m_cnt + 1;
                    m_sum = s;
                    m_cnt = n;
                    done = in_last || (n == LEN);
                    m_first = done;
                    if (done) begin
                        r = (s + (64'sd1 <<< (SH - 1))) >>> SH;
                        m_sat = (r > OMAX) || (r < OMIN);
                        m_data = (r > OMAX) ? OMAX : ((r < OMIN) ? OMIN : r);
                        m_err = !in_last;
                        m_len = n;
                        m_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Cycle compare against the model, sampled mid-cycle; also records delivered results.
    initial begin
        forever begin
            bit rdy_exp;
            @(negedge clk);
            rdy_exp = ce && (!m_valid || out_ready);
            n_cmp++;
            if (in_ready !== rdy_exp) begin
                n_fail++;
                $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, rdy_exp);
            end
            n_cmp++;
            if (out_valid !== m_valid) begin
                n_fail++;
                $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, m_valid);
            end
            n_cmp++;
            if (longint'($signed(out_data)) != m_data || out_sat !== m_sat ||
                out_err !== m_err || int'(out_len) != m_len) begin
                n_fail++;
                $display("FAIL out_regs t=%0t got d=%0d s=%b e=%b l=%0d want d=%0d s=%b e=%b l=%0d",
                         $time, $signed(out_data), out_sat, out_err, out_len,
                         m_data, m_sat, m_err, m_len);
            end
            if (ce && out_valid && out_ready)
                cap_q.push_back('{longint'($signed(out_data)), out_sat, out_err, int'(out_len)});
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Drive one beat and wait (bounded) until the model says it was taken.
    task automatic beat(input longint v, input bit last);
        int w;
        in_valid = 1'b1;
        in_prod  = PW'(v);
        in_last  = last;
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (!m_accepted && w < 20);
        if (!m_accepted) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_timeout value %0d not accepted in %0d cycles", v, w);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for the next delivered result and compare it with literals.
    task automatic expect_res(input string name, input longint d, input bit s,
                              input bit e, input int l);
        int   w;
        res_t r;
        w = 0;
        while (cap_q.size() == 0 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (cap_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s result_timeout got none want d=%0d", name, d);
        end else begin
            r = cap_q.pop_front();
            $display("result %s: d=%0d sat=%b err=%b len=%0d", name, r.data, r.sat, r.err, r.len);
            chk({name, "_data"}, r.data, d);
            chk({name, "_sat"},  longint'(r.sat), longint'(s));
            chk({name, "_err"},  longint'(r.err), longint'(e));
            chk({name, "_len"},  longint'(r.len), longint'(l));
        end
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b1; in_valid = 1'b0; in_prod = '0;
        in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_data",  longint'(out_data), 0);
        chk("rst_len",   longint'(out_len), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic and negative rounding.
        beat(100, 0); beat(200, 0); beat(300, 1);
        chk("basic_valid_next_cycle", longint'(out_valid), 1);
        expect_res("basic", 5, 0, 0, 3);
        beat(-100, 0); beat(-200, 0); beat(-300, 1);
        expect_res("negative", -5, 0, 0, 3);

        // Saturation in both directions.
        for (int i = 1; i <= 4; i++) beat(134217727, i == 4);
        expect_res("sat_pos", 1048575, 1, 0, 4);
        for (int i = 1; i <= 4; i++) beat(-134217728, i == 4);
        expect_res("sat_neg", -1048576, 1, 0, 4);

        // Backpressure: result held while the next terminating beat waits.
        out_ready = 1'b0;
        beat(1000, 1);
        in_valid = 1'b1; in_prod = PW'(2000); in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_data_stable", longint'($signed(out_data)), 8);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_same_cycle_data", longint'($signed(out_data)), 16);
        chk("bp_same_cycle_valid", longint'(out_valid), 1);
        in_valid = 1'b0; in_last = 1'b0;
        expect_res("bp_first", 8, 0, 0, 1);
        expect_res("bp_second", 16, 0, 0, 1);

        // Overrun with a ce freeze mid-burst; beat 65 opens the next burst.
        for (int i = 1; i <= 65; i++) begin
            if (i == 30) begin
                ce = 1'b0; in_valid = 1'b1; in_prod = PW'(1);
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("ce_low_in_ready", longint'(in_ready), 0);
                end
                ce = 1'b1; in_valid = 1'b0;
            end
            beat(1, 0);
        end
        expect_res("overrun", 1, 0, 1, 64);
        beat(5, 1);
        expect_res("after_overrun", 0, 0, 0, 2);
        for (int i = 1; i <= 64; i++) beat(1, i == 64);
        expect_res("last_at_max", 1, 0, 0, 64);

        // Reset mid-burst, then reset while holding a result.
        beat(100000, 0); beat(100000, 0);
        reset_n = 1'b0; #1;
        chk("midrst_data", longint'(out_data), 0);
        chk("midrst_len",  longint'(out_len), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cap_q.delete();
        out_ready = 1'b0;
        beat(50, 1);
        chk("hold_len_after_rst", longint'(out_len), 1);
        chk("hold_valid", longint'(out_valid), 1);
        reset_n = 1'b0; #1;
        chk("holdrst_valid", longint'(out_valid), 0);
        chk("holdrst_len",   longint'(out_len), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cap_q.delete();
        out_ready = 1'b1;
        beat(10, 1);
        expect_res("post_reset", 0, 0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
